fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer for the IF stage PC mux.
- Each cycle it picks the next-PC source from stall, branch-predict, resolve/undo, register-jump, immediate-jump and alert inputs.
- It tracks outstanding speculative branches and runs interrupt entry/exit.
- It sits between decode/execute hazard logic and the IF datapath; its pc_sel drives the IF next-PC mux.

Parameters:
- SPEC_MAX, 2, maximum outstanding predicted branches; counter width is clog2(SPEC_MAX+1).
- INT_VECTOR, 32'h0000_0100, interrupt handler address presented on int_vector.
- NEST_DEPTH, 4, maximum interrupt nesting (used only with NESTED_INT_EN).

Ports:
- clk  in  1  system clock. One clock; every flop is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold request.
- branch_predict  in  1  decode predicts taken this cycle.
- branch_resolve  in  1  execute confirms one prediction correct.
- branch_undo  in  1  execute flags a misprediction; flush all speculation.
- pcr_take  in  1  register jump / return-from-interrupt.
- pci_take  in  1  immediate jump.
- alert  in  1  external interrupt request pulse.
- pc_sel  out  3  0 SEQ, 1 HOLD, 2 BRANCH, 3 UNDO, 4 PCR, 5 PCI, 6 VECTOR.
- int_vector  out  32  constant INT_VECTOR.
- save_pc_en  out  1  capture the return PC (same cycle as VECTOR).
- interrupt  out  1  one-cycle pulse on interrupt entry.
- interrupt_mask  out  1  high while inside the handler.
- spec_full  out  1  speculative count == SPEC_MAX.

Behaviour:
- Reset values:
  - state RUN, spec_cnt 0, alert_pend 0.
  - interrupt 0, interrupt_mask 0, save_pc_en 0, spec_full 0.
  - pc_sel = HOLD while rst_n is low.
- pc_sel and save_pc_en are combinational from state and inputs. interrupt and interrupt_mask are registered.
- alert_pend is set on any cycle with alert=1 and cleared in the cycle that leaves ENTER. A new alert arriving in that same cycle wins, so alert_pend stays set.
- pc_sel priority, RUN / DRAIN / ISR states:
  1. branch_undo → UNDO
  2. pcr_take → PCR
  3. pci_take → PCI
  4. stall → HOLD
  5. DRAIN → HOLD
  6. branch_predict: BRANCH if !spec_full, else HOLD
  7. otherwise SEQ
- Speculation counter:
  - Increments only when BRANCH is selected.
  - Decrements on branch_resolve when spec_cnt > 0.
  - Increment and decrement in the same cycle leave it unchanged.
  - branch_undo forces 0, overriding both.
  - branch_resolve at 0 is ignored.
  - spec_full = (spec_cnt == SPEC_MAX).
- FSM:
  - RUN:
    - alert_pend|alert, mask clear, spec_cnt==0, !stall, no redirect this cycle → ENTER.
    - alert_pend|alert, mask clear, but any of those conditions fails → DRAIN.
  - DRAIN:
    - New fetch is held, but UNDO/PCR/PCI redirects are still honoured.
    - Exit to ENTER once spec_cnt==0 && !stall.
  - ENTER:
    - While stall=1: pc_sel HOLD, remain in ENTER.
    - Otherwise: pc_sel VECTOR, save_pc_en=1, next cycle interrupt=1 for one cycle and interrupt_mask=1, go to ISR.
    - All other inputs are ignored in ENTER.
  - ISR:
    - Alerts are latched only.
    - pcr_take → pc_sel PCR, go to RUN, interrupt_mask clears the next cycle.
    - An alert_pend still set is then serviced through the normal RUN rules.
- Entry latency: alert in cycle N with an idle pipe gives VECTOR in N+1 and interrupt high in N+2.
- Asynchronous reset mid-sequence (DRAIN/ENTER/ISR) returns to RUN and discards the pending alert.

Optional Feature:
- Macro: NESTED_INT_EN.
- Without it:
  - Nesting depth is fixed at 1.
  - An alert in ISR waits for pcr_take.
- With it:
  - ISR accepts alert_pend through DRAIN/ENTER while nest_cnt < NEST_DEPTH.
  - ENTER increments nest_cnt; pcr_take in ISR decrements it.
  - Leave to RUN, and clear interrupt_mask, only when nest_cnt reaches 0.
  - interrupt_mask reads (nest_cnt != 0).
  - An alert at depth NEST_DEPTH stays pending.

Test Plan:
- Reset release, no inputs → pc_sel SEQ every cycle, all outputs 0, spec_cnt 0.
- branch_predict for 3 consecutive cycles (SPEC_MAX=2) → BRANCH, BRANCH, HOLD; spec_full=1 after the second; one branch_resolve → spec_full=0, next predict → BRANCH.
- spec_cnt=2, branch_undo together with branch_predict and pci_take → pc_sel UNDO, spec_cnt=0, no increment.
- alert with spec_cnt=1 → DRAIN, pc_sel HOLD; branch_resolve → next cycle VECTOR with save_pc_en=1; following cycle interrupt=1 pulse, interrupt_mask=1.
- In ISR, alert then pcr_take → PCR, mask clears; second entry VECTOR two cycles after pcr_take. With NESTED_INT_EN: second VECTOR inside ISR, mask stays 1 until the second pcr_take.
- rst_n asserted while in ENTER with stall=1 → immediately pc_sel HOLD, state RUN, alert_pend 0, interrupt_mask 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// IF-stage next-PC sequencer: picks pc_sel, tracks speculative branches, runs interrupt entry/exit.
// Optional nested interrupts are enabled by defining NESTED_INT_EN.
module fetch_ctrl #(
   parameter int unsigned SPEC_MAX   = 2,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0100,
   parameter int unsigned NEST_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_predict,
   input  logic        branch_resolve,
   input  logic        branch_undo,
   input  logic        pcr_take,
   input  logic        pci_take,
   input  logic        alert,
   output logic [2:0]  pc_sel,
   output logic [31:0] int_vector,
   output logic        save_pc_en,
   output logic        interrupt,
   output logic        interrupt_mask,
   output logic        spec_full
);

`ifdef NESTED_INT_EN
   localparam bit NestEn = 1'b1;
`else
   localparam bit NestEn = 1'b0;
`endif

   // Without nesting the handler behaves as a nest of depth one.
   localparam int unsigned MaxNest = NestEn ? NEST_DEPTH : 1;
   localparam int unsigned NestW   = $clog2(MaxNest + 1);
   localparam int unsigned CntW    = $clog2(SPEC_MAX + 1);

   localparam logic [NestW-1:0] NestMaxV = NestW'(MaxNest);
   localparam logic [CntW-1:0]  SpecMaxV = CntW'(SPEC_MAX);

   localparam logic [2:0] PcSeq    = 3'd0;
   localparam logic [2:0] PcHold   = 3'd1;
   localparam logic [2:0] PcBranch = 3'd2;
   localparam logic [2:0] PcUndo   = 3'd3;
   localparam logic [2:0] PcPcr    = 3'd4;
   localparam logic [2:0] PcPci    = 3'd5;
   localparam logic [2:0] PcVector = 3'd6;

   localparam logic [1:0] StRun   = 2'd0;
   localparam logic [1:0] StDrain = 2'd1;
   localparam logic [1:0] StEnter = 2'd2;
   localparam logic [1:0] StIsr   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CntW-1:0]  spec_cnt_q, spec_cnt_d;
   logic [NestW-1:0] nest_q, nest_d;
   logic             alert_pend_q, alert_pend_d;
   logic             irq_q, irq_d;
   logic             mask_q, mask_d;

   logic in_enter;
   logic enter_go;
   logic alert_any;
   logic can_nest;
   logic quiet;
   logic spec_inc;
   logic spec_dec;

   assign in_enter  = (state_q == StEnter);
   assign enter_go  = in_enter & ~stall;
   assign alert_any = alert_pend_q | alert;
   assign can_nest  = (nest_q < NestMaxV);
   // A predicted branch this cycle would leave speculation outstanding, so it blocks direct entry.
   assign quiet     = (spec_cnt_q == '0) & ~stall & ~branch_undo & ~pcr_take & ~pci_take &
                      ~branch_predict;

   assign spec_full      = (spec_cnt_q == SpecMaxV);
   assign int_vector     = INT_VECTOR;
   assign save_pc_en     = rst_n & enter_go;
   assign interrupt      = irq_q;
   assign interrupt_mask = mask_q;

   always_comb begin
      pc_sel = PcSeq;
      if (!rst_n) begin
         pc_sel = PcHold;
      end else if (in_enter) begin
         pc_sel = stall ? PcHold : PcVector;
      end else if (branch_undo) begin
         pc_sel = PcUndo;
      end else if (pcr_take) begin
         pc_sel = PcPcr;
      end else if (pci_take) begin
         pc_sel = PcPci;
      end else if (stall || (state_q == StDrain)) begin
         pc_sel = PcHold;
      end else if (branch_predict) begin
         pc_sel = spec_full ? PcHold : PcBranch;
      end
   end

   always_comb begin
      spec_cnt_d = spec_cnt_q;
      spec_inc   = (pc_sel == PcBranch);
      spec_dec   = branch_resolve & (spec_cnt_q != '0) & ~in_enter;
      if (!in_enter && branch_undo) begin
         spec_cnt_d = '0;
      end else if (spec_inc && !spec_dec) begin
         spec_cnt_d = spec_cnt_q + CntW'(1);
      end else if (spec_dec && !spec_inc) begin
         spec_cnt_d = spec_cnt_q - CntW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      nest_d  = nest_q;
      case (state_q)
         StRun: begin
            if (alert_any && can_nest) begin
               state_d = quiet ? StEnter : StDrain;
            end
         end
         StDrain: begin
            if ((spec_cnt_d == '0) && !stall) begin
               state_d = StEnter;
            end
         end
         StEnter: begin
            if (!stall) begin
               state_d = StIsr;
               nest_d  = nest_q + NestW'(1);
            end
         end
         StIsr: begin
            if (pcr_take) begin
               nest_d = nest_q - NestW'(1);
               if (nest_q == NestW'(1)) begin
                  state_d = StRun;
               end
            end else if (alert_any && can_nest) begin
               state_d = quiet ? StEnter : StDrain;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // A fresh alert in the cycle that leaves ENTER keeps the pending flag set.
   assign alert_pend_d = alert | (alert_pend_q & ~enter_go);
   assign irq_d        = enter_go;
   assign mask_d       = (nest_d != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StRun;
         spec_cnt_q   <= '0;
         nest_q       <= '0;
         alert_pend_q <= 1'b0;
         irq_q        <= 1'b0;
         mask_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         spec_cnt_q   <= spec_cnt_d;
         nest_q       <= nest_d;
         alert_pend_q <= alert_pend_d;
         irq_q        <= irq_d;
         mask_q       <= mask_d;
      end
   end

endmodule
